// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier datapath.
package mult_pkg;

  localparam int N_DEF = 16;
  localparam int CNT_W = $clog2(N_DEF);
  localparam int ACC_W = 2 * N_DEF + 1;

endpackage

// File: rtl/mult_counter.sv
// Shift counter for the multiplier; K flags the last shift position (N-1).
module mult_counter #(
  parameter int N  = 16,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          K
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      // explicit wrap so non-power-of-two N still cycles 0..N-1
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign K = (count == LAST);

endmodule

// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath: ACC = {carry, upper, multiplier}, MC holds the multiplicand.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           Load,
  input  logic           Sh,
  input  logic           Ad,
  input  logic [N-1:0]   Mplier,
  input  logic [N-1:0]   Mcand,
  output logic           M,
  output logic           K,
  output logic [2*N-1:0] Product
);

  localparam int AW = 2 * N + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;
  logic [N-1:0]  mc;
  logic [N:0]    sum;
  logic [CW-1:0] count;

  assign sum = {1'b0, acc[2*N-1:N]} + {1'b0, mc};

  always_comb begin
    acc_nxt = acc;
    if (Load) begin
      acc_nxt = {{(N+1){1'b0}}, Mplier};
    end else if (Ad && Sh) begin
      // add then shift in one edge: the new carry lands in bit 2N-1
      acc_nxt = {1'b0, sum, acc[N-1:1]};
    end else if (Ad) begin
      acc_nxt = {sum, acc[N-1:0]};
    end else if (Sh) begin
      acc_nxt = {1'b0, acc[AW-1:1]};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc <= '0;
      mc  <= '0;
    end else begin
      acc <= acc_nxt;
      if (Load) mc <= Mcand;
    end
  end

  mult_counter #(.N(N), .CW(CW)) u_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (Load),
    .inc   (Sh && !Load),
    .count (count),
    .K     (K)
  );

  assign M       = acc[0];
  assign Product = acc[2*N-1:0];

endmodule
